// File: rtl/wx_loader_pkg.sv
// Shared widths, FSM state encoding and memory-target encoding for wx_loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wx_loader_pkg;

   localparam int WX_W_ADDR_LEN = 20;
   localparam int WX_W_DATA_LEN = 1;
   localparam int WX_W_SEL_LEN  = 2;
   localparam int WX_X_ADDR_LEN = 10;
   localparam int WX_X_DATA_LEN = 1;
   localparam int WX_X_SEL_LEN  = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic {
      TGT_W = 1'b0,
      TGT_X = 1'b1
   } tgt_t;

endpackage

// File: rtl/wx_loader.sv
// Streams a bit-serial load job into the weight (W) or activation (X) memory.
// Latency: one write strobe the cycle after each accepted beat; load_done len+2 cycles from start, counted inclusively.
// Backpressure: s_ready is high only in LOAD; s_valid gaps stall the job without penalty.
module wx_loader
   import wx_loader_pkg::*;
#(
   parameter int W_ADDR_LEN = WX_W_ADDR_LEN,
   parameter int W_DATA_LEN = WX_W_DATA_LEN,
   parameter int W_SEL_LEN  = WX_W_SEL_LEN,
   parameter int X_ADDR_LEN = WX_X_ADDR_LEN,
   parameter int X_DATA_LEN = WX_X_DATA_LEN,
   parameter int X_SEL_LEN  = WX_X_SEL_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  load_target,
   input  logic [1:0]            load_bank,
   input  logic [W_ADDR_LEN:0]   load_len,
   input  logic                  s_valid,
   input  logic                  s_data,
   output logic                  s_ready,
   output logic [W_ADDR_LEN-1:0] w_addr,
   output logic [W_DATA_LEN-1:0] w_data,
   output logic [W_SEL_LEN-1:0]  w_sel,
   output logic                  w_wq,
   output logic [X_ADDR_LEN-1:0] x_addr,
   output logic [X_DATA_LEN-1:0] x_data,
   output logic [X_SEL_LEN-1:0]  x_sel,
   output logic                  x_wq,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err
);

   localparam int LEN_W = W_ADDR_LEN + 1;
   // One bit wider than the length so the X depth itself is representable.
   localparam logic [LEN_W:0] X_MAX_LEN = (LEN_W + 1)'(1) << X_ADDR_LEN;

   state_t            state;
   state_t            state_nxt;
   tgt_t              tgt_q;
   logic [1:0]        bank_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic              accept;
   logic              last_beat;
   logic              start_err;

   // Beat acceptance, final-beat detection and oversize-X rejection.
   always_comb begin
      accept    = (state == S_LOAD) && s_valid;
      last_beat = accept && ((cnt + LEN_W'(1)) == len_q);
      start_err = (state == S_IDLE) && load_start &&
                  (tgt_t'(load_target) == TGT_X) &&
                  ({1'b0, load_len} > X_MAX_LEN);
   end

   // Next-state logic; a rejected job leaves the FSM in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (load_start && !start_err) begin
               state_nxt = (load_len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (last_beat) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign s_ready   = (state == S_LOAD);
   assign busy      = (state == S_LOAD);
   assign load_done = (state == S_DONE);

   // Job fields are captured only from IDLE so a mid-job start has no effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tgt_q  <= TGT_W;
         bank_q <= '0;
         len_q  <= '0;
         cnt    <= '0;
      end else if ((state == S_IDLE) && load_start) begin
         tgt_q  <= tgt_t'(load_target);
         bank_q <= load_bank;
         len_q  <= load_len;
         cnt    <= '0;
      end else if (accept) begin
         cnt <= cnt + LEN_W'(1);
      end
   end

   // Memory write ports: strobe one cycle after acceptance; addr/data/sel hold between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_wq     <= 1'b0;
         x_wq     <= 1'b0;
         load_err <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         w_sel    <= '0;
         x_addr   <= '0;
         x_data   <= '0;
         x_sel    <= '0;
      end else begin
         w_wq     <= accept && (tgt_q == TGT_W);
         x_wq     <= accept && (tgt_q == TGT_X);
         load_err <= start_err;
         if (accept && (tgt_q == TGT_W)) begin
            w_addr <= cnt[W_ADDR_LEN-1:0];
            w_data <= W_DATA_LEN'(s_data);
            w_sel  <= W_SEL_LEN'(bank_q);
         end
         if (accept && (tgt_q == TGT_X)) begin
            x_addr <= cnt[X_ADDR_LEN-1:0];
            x_data <= X_DATA_LEN'(s_data);
            x_sel  <= X_SEL_LEN'(bank_q);
         end
      end
   end

endmodule

// File: tb/tb_wx_loader.sv
// Randomised and directed bench for wx_loader against a job-level write model.
// Latency: checks load_done at len+2 cycles from start, counted inclusively.
// Backpressure: drives s_valid held, toggling and random to exercise stalls.
module tb_wx_loader;

   logic        clk;
   logic        rst;
   logic        load_start;
   logic        load_target;
   logic [1:0]  load_bank;
   logic [20:0] load_len;
   logic        s_valid;
   logic        s_data;
   logic        s_ready;
   logic [19:0] w_addr;
   logic [0:0]  w_data;
   logic [1:0]  w_sel;
   logic        w_wq;
   logic [9:0]  x_addr;
   logic [0:0]  x_data;
   logic [1:0]  x_sel;
   logic        x_wq;
   logic        busy;
   logic        load_done;
   logic        load_err;

   wx_loader dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .load_target(load_target),
      .load_bank(load_bank), .load_len(load_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .w_addr(w_addr), .w_data(w_data), .w_sel(w_sel), .w_wq(w_wq),
      .x_addr(x_addr), .x_data(x_data), .x_sel(x_sel), .x_wq(x_wq),
      .busy(busy), .load_done(load_done), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          tgt;
      int unsigned addr;
      bit          data;
      int unsigned sel;
      int unsigned cyc;
   } wr_t;

   wr_t         obs_q[$];
   bit          stim_bits [2048];
   int unsigned cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int unsigned done_cyc = 0;
   int          busy_cnt = 0;
   int          dual_viol = 0;
   int          hold_viol = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [19:0] pw_addr;
   logic [0:0]  pw_data;
   logic [1:0]  pw_sel;
   logic [9:0]  px_addr;
   logic [0:0]  px_data;
   logic [1:0]  px_sel;

   function automatic logic [63:0] pk(bit t, int unsigned a, bit d, int unsigned s);
      return {t, a, d, s[29:0]};
   endfunction

   // Cycle counter, advanced on every rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records every write strobe and pulse, flags held-value and dual-strobe violations.
   always @(negedge clk) begin
      wr_t w;
      if (!rst) begin
         pw_addr <= '0; pw_data <= '0; pw_sel <= '0;
         px_addr <= '0; px_data <= '0; px_sel <= '0;
      end else begin
         if (w_wq) begin
            w.tgt = 1'b0; w.addr = w_addr; w.data = w_data[0]; w.sel = w_sel; w.cyc = cyc;
            obs_q.push_back(w);
         end else if (w_addr !== pw_addr || w_data !== pw_data || w_sel !== pw_sel) begin
            hold_viol <= hold_viol + 1;
         end
         if (x_wq) begin
            w.tgt = 1'b1; w.addr = x_addr; w.data = x_data[0]; w.sel = x_sel; w.cyc = cyc;
            obs_q.push_back(w);
         end else if (x_addr !== px_addr || x_data !== px_data || x_sel !== px_sel) begin
            hold_viol <= hold_viol + 1;
         end
         if (w_wq && x_wq) dual_viol <= dual_viol + 1;
         if (load_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (load_err) err_cnt <= err_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;
         pw_addr <= w_addr; pw_data <= w_data; pw_sel <= w_sel;
         px_addr <= x_addr; px_data <= x_data; px_sel <= x_sel;
      end
   end

   // Issue one job and stream its beats; gap_mode 0 held, 1 toggling, 2 random.
   task automatic run_job(input bit tgt, input int bank, input int len, input int gap_mode,
                          input int restart_at, input int abort_after,
                          output int unsigned start_cyc, output bit timeout);
      int idx;
      int step;
      bit v;
      bit acc;
      bit restarted;
      idx = 0; step = 0; timeout = 1'b0; restarted = 1'b0;
      @(negedge clk);
      load_start  = 1'b1;
      load_target = tgt;
      load_bank   = bank[1:0];
      load_len    = len[20:0];
      start_cyc   = cyc;
      @(negedge clk);
      load_start = 1'b0;
      while (idx < len) begin
         if (idx == abort_after) break;
         if (step > 4 * len + 50) begin
            timeout = 1'b1;
            break;
         end
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (step % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         s_valid = v;
         s_data  = stim_bits[idx];
         if (idx == restart_at && !restarted) begin
            load_start  = 1'b1;
            load_target = ~tgt;
            load_bank   = ~bank[1:0];
            load_len    = 21'd3;
            restarted   = 1'b1;
         end else begin
            load_start = 1'b0;
         end
         acc = s_ready && v;
         @(negedge clk);
         if (acc) idx++;
         step++;
      end
      s_valid    = 1'b0;
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({s_ready, busy, load_done, load_err, w_wq, x_wq} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000", {s_ready, busy, load_done, load_err, w_wq, x_wq});
      end
      n_checks++;
      if ({w_addr, w_data, w_sel} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_w_port: got %h expected 0", {w_addr, w_data, w_sel});
      end
      n_checks++;
      if ({x_addr, x_data, x_sel} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_x_port: got %h expected 0", {x_addr, x_data, x_sel});
      end
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic test_w_job();
      logic [7:0]  pat;
      int          base, d0, b0, bad;
      int unsigned sc;
      bit          to;
      pat = 8'b10110010;
      for (int k = 0; k < 8; k++) stim_bits[k] = pat[7-k];
      base = obs_q.size(); d0 = done_cnt; b0 = busy_cnt;
      run_job(1'b0, 2, 8, 0, -1, -1, sc, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL w_job_timeout: beats not all accepted"); end
      n_checks++;
      if ({w_wq, x_wq, s_ready, load_done, busy} !== 5'b10010) begin
         n_fail++;
         $display("FAIL w_job_final_cycle: got %b expected 10010", {w_wq, x_wq, s_ready, load_done, busy});
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (obs_q.size() - base !== 8) begin
         n_fail++; $display("FAIL w_job_count: got %0d expected 8", obs_q.size() - base);
      end
      bad = 0;
      for (int k = 0; k < 8 && base + k < obs_q.size(); k++)
         if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
             !== pk(1'b0, k, stim_bits[k], 2)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL w_job_data: got %0d bad writes expected 0", bad); end
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL w_job_done: got %0d expected 1", done_cnt - d0); end
      n_checks++;
      if (done_cyc - sc + 1 !== 10) begin
         n_fail++; $display("FAIL w_job_latency: got %0d expected 10", done_cyc - sc + 1);
      end
      n_checks++;
      if (busy_cnt - b0 !== 8) begin n_fail++; $display("FAIL w_job_busy: got %0d expected 8", busy_cnt - b0); end
   endtask

   task automatic test_x_toggle();
      int          base, d0, bad;
      int unsigned sc;
      bit          to;
      for (int k = 0; k < 4; k++) stim_bits[k] = 1'($urandom_range(0, 1));
      base = obs_q.size(); d0 = done_cnt;
      run_job(1'b1, 1, 4, 1, -1, -1, sc, to);
      repeat (2) @(negedge clk);
      n_checks++;
      if (to || obs_q.size() - base !== 4) begin
         n_fail++; $display("FAIL x_toggle_count: got %0d expected 4 (timeout %0d)", obs_q.size() - base, to);
      end
      bad = 0;
      for (int k = 0; k < 4 && base + k < obs_q.size(); k++)
         if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
             !== pk(1'b1, k, stim_bits[k], 1)) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL x_toggle_data: got %0d bad writes expected 0", bad); end
      n_checks++;
      if (done_cnt - d0 !== 1 || obs_q.size() < base + 4 || done_cyc !== obs_q[base+3].cyc) begin
         n_fail++; $display("FAIL x_toggle_done: got done cycle %0d expected final write cycle", done_cyc);
      end
   endtask

   task automatic test_x_err();
      int          base, d0, e0, b0;
      int unsigned sc;
      bit          to;
      base = obs_q.size(); d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
      run_job(1'b1, 3, 1025, 0, -1, 0, sc, to);
      n_checks++;
      if ({load_err, busy, s_ready} !== 3'b100) begin
         n_fail++; $display("FAIL x_err_pulse: got %b expected 100", {load_err, busy, s_ready});
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL x_err_count: got %0d expected 1", err_cnt - e0); end
      n_checks++;
      if (obs_q.size() - base !== 0 || busy_cnt - b0 !== 0 || done_cnt - d0 !== 0) begin
         n_fail++;
         $display("FAIL x_err_side_effects: writes %0d busy %0d done %0d expected 0 0 0",
                  obs_q.size() - base, busy_cnt - b0, done_cnt - d0);
      end
   endtask

   task automatic test_x_max_len();
      int          base, bad;
      int unsigned sc;
      bit          to;
      for (int k = 0; k < 1024; k++) stim_bits[k] = 1'($urandom_range(0, 1));
      base = obs_q.size();
      run_job(1'b1, 0, 1024, 0, -1, -1, sc, to);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 1024 && base + k < obs_q.size(); k++)
         if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
             !== pk(1'b1, k, stim_bits[k], 0)) bad++;
      n_checks++;
      if (to || bad != 0 || obs_q.size() - base !== 1024) begin
         n_fail++; $display("FAIL x_max_len: got %0d writes %0d bad expected 1024 writes 0 bad", obs_q.size() - base, bad);
      end
      n_checks++;
      if (done_cyc - sc + 1 !== 1026) begin
         n_fail++; $display("FAIL x_max_latency: got %0d expected 1026", done_cyc - sc + 1);
      end
   endtask

   task automatic test_len0();
      int          base, d0;
      int unsigned sc;
      bit          to;
      base = obs_q.size(); d0 = done_cnt;
      run_job(1'b0, 1, 0, 0, -1, -1, sc, to);
      n_checks++;
      if ({load_done, busy, s_ready} !== 3'b100) begin
         n_fail++; $display("FAIL len0_done: got %b expected 100", {load_done, busy, s_ready});
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 1 || done_cyc - sc + 1 !== 2 || obs_q.size() - base !== 0) begin
         n_fail++;
         $display("FAIL len0_latency: done %0d latency %0d writes %0d expected 1 2 0",
                  done_cnt - d0, done_cyc - sc + 1, obs_q.size() - base);
      end
   endtask

   task automatic test_reset_mid_job();
      int          base, d0, bad;
      int unsigned sc;
      bit          to;
      for (int k = 0; k < 8; k++) stim_bits[k] = 1'($urandom_range(0, 1));
      base = obs_q.size(); d0 = done_cnt;
      run_job(1'b0, 3, 8, 0, -1, 3, sc, to);
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({w_wq, x_wq, busy, s_ready, load_done, w_addr, w_data, w_sel} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %h expected 0", {w_wq, x_wq, busy, s_ready, load_done, w_addr, w_data, w_sel});
      end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 0 || obs_q.size() - base !== 3) begin
         n_fail++;
         $display("FAIL reset_mid_abort: done %0d writes %0d expected 0 3", done_cnt - d0, obs_q.size() - base);
      end
      for (int k = 0; k < 5; k++) stim_bits[k] = 1'($urandom_range(0, 1));
      base = obs_q.size(); d0 = done_cnt;
      run_job(1'b0, 1, 5, 0, -1, -1, sc, to);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 5 && base + k < obs_q.size(); k++)
         if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
             !== pk(1'b0, k, stim_bits[k], 1)) bad++;
      n_checks++;
      if (to || bad != 0 || obs_q.size() - base !== 5 || done_cnt - d0 !== 1) begin
         n_fail++;
         $display("FAIL reset_mid_rerun: writes %0d bad %0d done %0d expected 5 0 1",
                  obs_q.size() - base, bad, done_cnt - d0);
      end
   endtask

   task automatic test_restart_ignored();
      int          base, d0, b0, bad;
      int unsigned sc;
      bit          to;
      for (int k = 0; k < 6; k++) stim_bits[k] = 1'($urandom_range(0, 1));
      base = obs_q.size(); d0 = done_cnt; b0 = busy_cnt;
      run_job(1'b1, 2, 6, 0, 2, -1, sc, to);
      repeat (3) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 6 && base + k < obs_q.size(); k++)
         if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
             !== pk(1'b1, k, stim_bits[k], 2)) bad++;
      n_checks++;
      if (to || bad != 0 || obs_q.size() - base !== 6) begin
         n_fail++; $display("FAIL restart_writes: got %0d writes %0d bad expected 6 0", obs_q.size() - base, bad);
      end
      n_checks++;
      if (done_cnt - d0 !== 1 || done_cyc - sc + 1 !== 8 || busy_cnt - b0 !== 6) begin
         n_fail++;
         $display("FAIL restart_timing: done %0d latency %0d busy %0d expected 1 8 6",
                  done_cnt - d0, done_cyc - sc + 1, busy_cnt - b0);
      end
   endtask

   task automatic test_random_jobs();
      int          base, d0, bad, len, bank, mode;
      bit          tgt;
      int unsigned sc;
      bit          to;
      for (int j = 0; j < 10; j++) begin
         tgt  = 1'($urandom_range(0, 1));
         bank = $urandom_range(0, 3);
         len  = $urandom_range(1, 40);
         mode = (j % 2 == 0) ? 0 : 2;
         for (int k = 0; k < len; k++) stim_bits[k] = 1'($urandom_range(0, 1));
         base = obs_q.size(); d0 = done_cnt;
         run_job(tgt, bank, len, mode, -1, -1, sc, to);
         repeat (2) @(negedge clk);
         bad = 0;
         for (int k = 0; k < len && base + k < obs_q.size(); k++)
            if (pk(obs_q[base+k].tgt, obs_q[base+k].addr, obs_q[base+k].data, obs_q[base+k].sel)
                !== pk(tgt, k, stim_bits[k], bank)) bad++;
         n_checks++;
         if (to || bad != 0 || obs_q.size() - base !== len || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL random_job%0d: writes %0d bad %0d done %0d expected %0d 0 1",
                     j, obs_q.size() - base, bad, done_cnt - d0, len);
         end
         if (mode == 0) begin
            n_checks++;
            if (done_cyc - sc + 1 !== len + 2) begin
               n_fail++; $display("FAIL random_latency%0d: got %0d expected %0d", j, done_cyc - sc + 1, len + 2);
            end
         end
      end
   endtask

   task automatic test_invariants();
      n_checks++;
      if (dual_viol !== 0) begin n_fail++; $display("FAIL dual_strobe: got %0d expected 0", dual_viol); end
      n_checks++;
      if (hold_viol !== 0) begin n_fail++; $display("FAIL hold_values: got %0d expected 0", hold_viol); end
   endtask

   initial begin
      load_start = 1'b0; load_target = 1'b0; load_bank = 2'd0; load_len = '0;
      s_valid = 1'b0; s_data = 1'b0;
      test_reset();
      test_w_job();
      test_x_toggle();
      test_x_err();
      test_len0();
      test_reset_mid_job();
      test_restart_ignored();
      test_x_max_len();
      test_random_jobs();
      test_invariants();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
